// File: rtl/seg_scan_if.sv
// Frame-load and display bus between the game FSM (master) and the digit/bar scanner (slave).
interface seg_scan_if #(
    parameter int N_DIGITS  = 8,
    parameter int N_BARS    = 2,
    parameter int BAR_WIDTH = 8
);
    logic                          load;
    logic [4*N_DIGITS-1:0]         char_in;
    logic [N_DIGITS-1:0]           dp_in;
    logic [N_DIGITS-1:0]           en_in;
    logic [N_DIGITS-1:0]           blink_in;
    logic [4*N_BARS-1:0]           bar_value;
    logic [N_DIGITS-1:0]           AN;
    logic [7:0]                    DDP;
    logic [N_BARS*BAR_WIDTH-1:0]   LED;
    logic                          frame_done;

    modport master (
        output load, char_in, dp_in, en_in, blink_in, bar_value,
        input  AN, DDP, LED, frame_done
    );
    modport slave (
        input  load, char_in, dp_in, en_in, blink_in, bar_value,
        output AN, DDP, LED, frame_done
    );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner with double-buffered frames, per-digit blink and
// thermometer score bars; single clock, dwell counter instead of a derived scan clock.
module seg_scan_display #(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125,
    parameter int N_BARS       = 2,
    parameter int BAR_WIDTH    = 8
) (
    input  logic      clock,
    input  logic      reset,
    seg_scan_if.slave bus
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DWL_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int FW    = 7 * N_DIGITS;
    localparam int LW    = N_BARS * BAR_WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100001;
            4'h6: g = 7'b0000011;
            4'h7: g = 7'b1110001;
            4'h8: g = 7'b1000100;
            4'h9: g = 7'b0011000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0100100;
            4'hD: g = 7'b1110000;
            4'hE: g = 7'b0110000;
            4'hF: g = 7'b1000001;
        endcase
        return g;
    endfunction

    // Bit i lights when i >= BAR_WIDTH - min(v, BAR_WIDTH): fills from the MSB down.
    function automatic logic [BAR_WIDTH-1:0] bar_fill(input logic [3:0] v);
        logic [BAR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < BAR_WIDTH; i++)
            if ((32'(v) + 32'(i)) >= 32'(BAR_WIDTH)) r[i] = 1'b1;
        return r;
    endfunction

    // Frame layout: {blink, en, dp, char}
    logic [FW-1:0]       sh_q, sh_d, ac_q, ac_d, in_frame;
    logic                pend_q, pend_d, started_q, started_d, phase_q, phase_d;
    logic [DWL_W-1:0]    dwell_q, dwell_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FRM_W-1:0]    frm_q, frm_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          ddp_q, ddp_d;
    logic [LW-1:0]       led_q, led_d;
    logic                fd_q, fd_d;
    logic                term, bnd, lit;
    int unsigned         k;

    assign in_frame = {bus.blink_in, bus.en_in, bus.dp_in, bus.char_in};

    always_comb begin
        sh_d      = sh_q;
        ac_d      = ac_q;
        pend_d    = pend_q;
        started_d = started_q;
        phase_d   = phase_q;
        frm_d     = frm_q;
        idx_d     = idx_q;
        an_d      = an_q;
        ddp_d     = ddp_q;
        lit       = 1'b0;
        k         = 0;

        term    = (dwell_q == DWL_LAST);
        dwell_d = term ? '0 : dwell_q + DWL_W'(1);
        // The very first terminal count lands on digit 0 rather than advancing past it.
        bnd       = term && (!started_q || idx_q == IDX_LAST);
        fd_d      = bnd && started_q;
        started_d = started_q | term;

        if (bus.load) begin
            sh_d   = in_frame;
            pend_d = 1'b1;
        end
        if (bnd) begin
            if (bus.load)   ac_d = in_frame;
            else if (pend_q) ac_d = sh_q;
            pend_d = 1'b0;
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end

        if (term) begin
            idx_d = bnd ? '0 : idx_q + IDX_W'(1);
            k     = 32'(idx_d);
            lit   = ac_d[5*N_DIGITS + k] && !(ac_d[6*N_DIGITS + k] && phase_d);
            an_d  = lit ? ~(N_DIGITS'(1) << idx_d) : '1;
            ddp_d = lit ? {glyph(ac_d[4*k +: 4]), ~ac_d[4*N_DIGITS + k]} : 8'hFF;
        end

        for (int b = 0; b < N_BARS; b++)
            led_d[b*BAR_WIDTH +: BAR_WIDTH] = bar_fill(bus.bar_value[4*b +: 4]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sh_q      <= '0;
            ac_q      <= '0;
            pend_q    <= 1'b0;
            started_q <= 1'b0;
            phase_q   <= 1'b0;
            frm_q     <= '0;
            dwell_q   <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            ddp_q     <= 8'hFF;
            led_q     <= '0;
            fd_q      <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            ac_q      <= ac_d;
            pend_q    <= pend_d;
            started_q <= started_d;
            phase_q   <= phase_d;
            frm_q     <= frm_d;
            dwell_q   <= dwell_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            ddp_q     <= ddp_d;
            led_q     <= led_d;
            fd_q      <= fd_d;
        end
    end

    assign bus.AN         = an_q;
    assign bus.DDP        = ddp_q;
    assign bus.LED        = led_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: N_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, two 8-LED bars.
module tb_seg_scan_display;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    seg_scan_if #(.N_DIGITS(4), .N_BARS(2), .BAR_WIDTH(8)) bus();

    seg_scan_display #(
        .N_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .N_BARS(2), .BAR_WIDTH(8)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic set_frame(input logic [15:0] c, input logic [3:0] dp,
                             input logic [3:0] en, input logic [3:0] bl);
        bus.char_in  = c;
        bus.dp_in    = dp;
        bus.en_in    = en;
        bus.blink_in = bl;
    endtask

    task automatic chk_digit(input string tag, input logic [3:0] an, input logic [7:0] ddp);
        chk({tag, "_AN"}, 32'(bus.AN), 32'(an));
        chk({tag, "_DDP"}, 32'(bus.DDP), 32'(ddp));
    endtask

    initial begin
        bus.load      = 1'b0;
        bus.bar_value = 8'h99;
        set_frame(16'h0, 4'h0, 4'h0, 4'h0);

        // Reset held for three edges.
        tick(); tick(); tick();
        chk("rst_AN", 32'(bus.AN), 32'hF);
        chk("rst_DDP", 32'(bus.DDP), 32'hFF);
        chk("rst_LED", 32'(bus.LED), 32'h0);
        chk("rst_FD", 32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;
        bus.bar_value = 8'h00;
        cyc = 0;

        // Blank run: boundaries at 4 (first, no pulse), 20, 36.
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("blank_AN", 32'(bus.AN), 32'hF);
            chk("blank_DDP", 32'(bus.DDP), 32'hFF);
            chk("blank_LED", 32'(bus.LED), 32'h0);
            chk("blank_FD", 32'(bus.frame_done), (cyc == 20 || cyc == 36) ? 32'h1 : 32'h0);
        end

        // Load 6125, all enabled, dp on digit 0; shown from boundary 52.
        set_frame(16'h6125, 4'b0001, 4'hF, 4'h0);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        run_to(51);
        chk("pre_load_AN", 32'(bus.AN), 32'hF);
        run_to(52);
        chk_digit("ld_d0", 4'hE, 8'b01000010);
        chk("ld_FD", 32'(bus.frame_done), 32'h1);
        run_to(53);
        chk("ld_FD_low", 32'(bus.frame_done), 32'h0);
        run_to(55);
        chk_digit("ld_d0_hold", 4'hE, 8'b01000010);
        run_to(56);
        chk_digit("ld_d1", 4'hD, 8'b00100101);
        run_to(60);
        chk_digit("ld_d2", 4'hB, 8'b10011111);
        run_to(64);
        chk_digit("ld_d3", 4'h7, 8'b00000111);

        // Tear-free: load frame B (ABCD) mid-frame at edge 70.
        run_to(69);
        set_frame(16'hABCD, 4'b0000, 4'hF, 4'h0);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        run_to(72);
        chk_digit("tf_d1_old", 4'hD, 8'b00100101);
        run_to(80);
        chk_digit("tf_d3_old", 4'h7, 8'b00000111);
        run_to(84);
        chk_digit("tf_d0_new", 4'hE, 8'b11100001);
        run_to(88);
        chk_digit("tf_d1_new", 4'hD, 8'b01001001);
        run_to(92);
        chk_digit("tf_d2_new", 4'hB, 8'b11000001);
        run_to(96);
        chk_digit("tf_d3_new", 4'h7, 8'b00010001);

        // Load coinciding with the wrap edge 100 goes straight to the active frame.
        run_to(99);
        set_frame(16'h789E, 4'b0000, 4'hF, 4'h0);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        chk_digit("sim_d0", 4'hE, 8'b01100001);
        chk("sim_pending", 32'(dut.pend_q), 32'h0);
        chk("sim_FD", 32'(bus.frame_done), 32'h1);

        // Blink frame: all zeros, digit 1 blinks; active from boundary 116.
        set_frame(16'h0000, 4'b0000, 4'hF, 4'b0010);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        run_to(112);
        chk_digit("sim_d3", 4'h7, 8'b11100011);
        run_to(116);
        chk_digit("bl_d0", 4'hE, 8'b00000011);
        run_to(120);
        chk_digit("bl_d1_on_a", 4'hD, 8'b00000011);
        run_to(136);
        chk_digit("bl_d1_on_b", 4'hD, 8'b00000011);
        run_to(148);
        chk_digit("bl_d0_phase1", 4'hE, 8'b00000011);
        run_to(152);
        chk_digit("bl_d1_off_a", 4'hF, 8'hFF);
        run_to(156);
        chk_digit("bl_d2_phase1", 4'hB, 8'b00000011);
        run_to(168);
        chk_digit("bl_d1_off_b", 4'hF, 8'hFF);
        run_to(184);
        chk_digit("bl_d1_on_c", 4'hD, 8'b00000011);

        // Bars: one-cycle latency, saturation at BAR_WIDTH.
        run_to(185);
        bus.bar_value = 8'h93;
        tick();
        chk("bar_9_3", 32'(bus.LED), 32'hFFE0);
        bus.bar_value = 8'h81;
        tick();
        chk("bar_8_1", 32'(bus.LED), 32'hFF80);
        bus.bar_value = 8'h00;
        tick();
        chk("bar_0_0", 32'(bus.LED), 32'h0000);

        // Reset mid-frame with a load pending: scan restarts and the load is dropped.
        set_frame(16'h1111, 4'hF, 4'hF, 4'h0);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.bar_value = 8'h55;
        rst_n = 1'b0;
        tick(); tick();
        chk("rst2_AN", 32'(bus.AN), 32'hF);
        chk("rst2_DDP", 32'(bus.DDP), 32'hFF);
        chk("rst2_LED", 32'(bus.LED), 32'h0);
        chk("rst2_FD", 32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;
        bus.bar_value = 8'h00;
        cyc = 0;
        run_to(4);
        chk_digit("rst2_first", 4'hF, 8'hFF);
        chk("rst2_first_FD", 32'(bus.frame_done), 32'h0);
        run_to(20);
        chk_digit("rst2_wrap", 4'hF, 8'hFF);
        chk("rst2_wrap_FD", 32'(bus.frame_done), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
